// File: rtl/itoa_pkg.sv
// Shared types and constants for the integer-to-ASCII formatter.
// The digit-stack depth is derived from the input width, so any DSZ gets a stack that is large enough.
package itoa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    PUSH,
    SGN,
    EMIT,
    TERM,
    DONE
  } itoa_sts;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_MINUS = 8'h2d;
  localparam logic [7:0] CH_NUL   = 8'h00;

  function automatic int ndig(input int dsz);
    return dsz / 3 + 1;
  endfunction

  // Converts one digit to a character. Hex letters are lowercase.
  function automatic logic [7:0] dig2chr(input logic [3:0] d);
    if (d < 4'd10) return CH_0 + {4'h0, d};
    else           return CH_A + {4'h0, d} - 8'd10;
  endfunction

endpackage

// File: rtl/itoa_if.sv
// Request/response bundle between a number-output requester and the itoa formatter.
// The requester holds en high for the whole run. The formatter streams one byte per cycle on we/ao/dout.
interface itoa_if #(
  parameter int DSZ = 32,
  parameter int ASZ = 5
);
  logic           en;
  logic           hex;
  logic           sgn;
  logic [DSZ-1:0] vi;
  logic           bsy;
  logic           we;
  logic [ASZ-1:0] ao;
  logic [7:0]     dout;
  logic [ASZ-1:0] len;

  modport master (output en, hex, sgn, vi, input bsy, we, ao, dout, len);
  modport slave  (input en, hex, sgn, vi, output bsy, we, ao, dout, len);
endinterface

// File: rtl/itoa_divu10.sv
// Sequential restoring divide-by-10. It produces one quotient bit per clock, MSB first.
// The first step is taken on the start edge, and done marks the cycle whose edge completes q and r.
module itoa_divu10
  import itoa_pkg::*;
#(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DSZ-1:0] n,
  output logic [DSZ-1:0] q,
  output logic [3:0]     r,
  output logic           done
);

  localparam int CW = $clog2(DSZ + 1);

  logic [CW-1:0]  cnt;
  logic           run;
  logic [DSZ-1:0] q_src;
  logic [3:0]     r_src;
  logic [4:0]     trial;
  logic [DSZ-1:0] q_nxt;
  logic [3:0]     r_nxt;

  // q doubles as the dividend shift register, and its vacated LSBs collect quotient bits.
  always_comb begin
    q_src = start ? n : q;
    r_src = start ? 4'd0 : r;
    trial = {r_src, q_src[DSZ-1]};
    if (trial >= 5'd10) begin
      r_nxt = 4'(trial - 5'd10);
      q_nxt = {q_src[DSZ-2:0], 1'b1};
    end else begin
      r_nxt = trial[3:0];
      q_nxt = {q_src[DSZ-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      r   <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else begin
      if (start || run) begin
        q <= q_nxt;
        r <= r_nxt;
      end
      if (start) begin
        cnt <= CW'(DSZ - 1);
        run <= 1'b1;
      end else if (run) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) run <= 1'b0;
      end
    end
  end

  assign done = run && (cnt == CW'(1));

endmodule

// File: rtl/itoa.sv
// Integer-to-ASCII formatter. It writes the decimal or hex text of vi, MSB digit first, followed by NUL.
// Digits come out of the divider LSB first, so they are held on a small stack and popped during EMIT.
//   state | meaning
//   IDLE  | waiting for en, latches inputs
//   DIV   | one division step by the base (1 cycle hex, DSZ cycles decimal)
//   PUSH  | push remainder, replace magnitude by quotient
//   SGN   | write '-' if negative
//   EMIT  | pop and write one digit per cycle
//   TERM  | write NUL at ao=len
//   DONE  | finished, hold len until en drops
module itoa
  import itoa_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int ASZ = 5
) (
  input  logic  clk,
  input  logic  rst,
  itoa_if.slave bus
);

  localparam int NDIG = ndig(DSZ);
  localparam int SPW  = $clog2(NDIG + 1);

  itoa_sts        state, state_nxt;
  logic           hex_r, neg_r, div_first;
  logic [DSZ-1:0] mag;
  logic [3:0]     stk [NDIG];
  logic [SPW-1:0] sp, top_idx;
  logic [ASZ-1:0] ao_r, len_r;

  logic [DSZ-1:0] dv_q, quot;
  logic [3:0]     dv_r, digit;
  logic           dv_done, dv_start;

  assign dv_start = div_first && !hex_r;
  assign quot     = hex_r ? (mag >> 4) : dv_q;
  assign digit    = hex_r ? mag[3:0] : dv_r;
  assign top_idx  = sp - SPW'(1);

  itoa_divu10 #(.DSZ(DSZ)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (dv_start),
    .n     (mag),
    .q     (dv_q),
    .r     (dv_r),
    .done  (dv_done)
  );

  always_comb begin
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = DIV;
        DIV:     if (hex_r || dv_done) state_nxt = PUSH;
        PUSH:    state_nxt = (quot == '0) ? SGN : DIV;
        SGN:     state_nxt = EMIT;
        EMIT:    if (sp == SPW'(1)) state_nxt = TERM;
        TERM:    state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hex_r     <= 1'b0;
      neg_r     <= 1'b0;
      div_first <= 1'b0;
      mag       <= '0;
      sp        <= '0;
      ao_r      <= '0;
      len_r     <= '0;
      for (int i = 0; i < NDIG; i++) stk[i] <= '0;
    end else begin
      state     <= state_nxt;
      div_first <= (state_nxt == DIV) && (state != DIV);
      if (!bus.en) begin
        ao_r  <= '0;
        len_r <= '0;
        sp    <= '0;
      end else begin
        case (state)
          IDLE: begin
            hex_r <= bus.hex;
            neg_r <= bus.sgn & bus.vi[DSZ-1];
            mag   <= (bus.sgn & bus.vi[DSZ-1]) ? (~bus.vi + DSZ'(1)) : bus.vi;
            sp    <= '0;
            ao_r  <= '0;
            len_r <= '0;
          end
          PUSH: begin
            stk[sp] <= digit;
            sp      <= sp + SPW'(1);
            mag     <= quot;
          end
          SGN: if (neg_r) begin
            ao_r  <= ao_r + ASZ'(1);
            len_r <= len_r + ASZ'(1);
          end
          EMIT: begin
            sp    <= top_idx;
            ao_r  <= ao_r + ASZ'(1);
            len_r <= len_r + ASZ'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.we   = 1'b0;
    bus.dout = CH_NUL;
    case (state)
      SGN: if (neg_r) begin
        bus.we   = 1'b1;
        bus.dout = CH_MINUS;
      end
      EMIT: begin
        bus.we   = 1'b1;
        bus.dout = dig2chr(stk[top_idx]);
      end
      TERM: begin
        bus.we   = 1'b1;
        bus.dout = CH_NUL;
      end
      default: ;
    endcase
  end

  assign bus.bsy = (state != IDLE) && (state != DONE);
  assign bus.ao  = ao_r;
  assign bus.len = len_r;

  a_no_stack_overflow: assert property (@(posedge clk) disable iff (rst)
    (state == PUSH) |-> (sp < SPW'(NDIG)));

endmodule

// File: tb/tb_itoa.sv
// Directed and round-trip checks for itoa. Written bytes are captured by ao,
// then compared with hand-computed strings or parsed back to an integer.
module tb_itoa;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  itoa_if #(.DSZ(32), .ASZ(5)) bus ();

  itoa #(.DSZ(32), .ASZ(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] wbuf [32];
  int nwr, lat, got_len, wecnt;
  bit ao_bad, fin;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_str(input string s);
    logic [127:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[119:0], s[i]};
    return v;
  endfunction

  function automatic logic [127:0] pack_buf(input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[119:0], wbuf[i]};
    return v;
  endfunction

  // Reference parser (atoi) for the captured text.
  function automatic logic [31:0] parse(input bit h, input int n);
    logic [31:0] acc = '0;
    bit neg = 0;
    int i = 0;
    logic [7:0] c;
    if (n > 0 && wbuf[0] == 8'h2d) begin
      neg = 1;
      i = 1;
    end
    for (; i < n; i++) begin
      c = wbuf[i];
      acc = acc * (h ? 32'd16 : 32'd10) +
            ((c >= 8'h61) ? 32'(c - 8'h61 + 8'd10) : 32'(c - 8'h30));
    end
    return neg ? -acc : acc;
  endfunction

  task automatic convert(input bit h, input bit s, input logic [31:0] v);
    @(negedge clk);
    bus.hex = h;
    bus.sgn = s;
    bus.vi  = v;
    bus.en  = 1'b1;
    nwr = 0; lat = 0; ao_bad = 0; fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.we) begin
        if (int'(bus.ao) != nwr) ao_bad = 1;
        if (nwr < 32) wbuf[nwr] = bus.dout;
        nwr++;
      end
      if (!bus.bsy) fin = 1;
    end
    chk("finished", fin, 1);
    got_len = int'(bus.len);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic directed(input bit h, input bit s, input logic [31:0] v,
                          input string e, input int exp_lat);
    convert(h, s, v);
    chk({e, " text"}, pack_buf(nwr > 0 ? nwr - 1 : 0), pack_str(e));
    chk({e, " len"}, got_len, e.len());
    chk({e, " writes"}, nwr, e.len() + 1);
    chk({e, " nul"}, (nwr > 0 && nwr <= 32) ? wbuf[nwr-1] : 8'hff, 8'h00);
    chk({e, " ao order"}, ao_bad, 0);
    chk({e, " latency"}, lat, exp_lat);
  endtask

  initial begin
    bus.en = 1'b0; bus.hex = 1'b0; bus.sgn = 1'b0; bus.vi = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {bus.bsy, bus.we, bus.ao, bus.dout, bus.len}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle outputs", {bus.bsy, bus.we, bus.ao, bus.dout, bus.len}, '0);

    directed(1, 0, 32'h0000_001F, "1f",          9);
    directed(0, 0, 32'h0000_0000, "0",           37);
    directed(0, 1, -32'sd123,     "-123",        105);
    directed(0, 1, 32'h8000_0000, "-2147483648", 343);
    directed(0, 0, 32'h8000_0000, "2147483648",  343);
    directed(0, 0, 32'hFFFF_FFFF, "4294967295",  343);
    directed(1, 0, 32'hFFFF_FFFF, "ffffffff",    27);
    directed(1, 1, 32'hFFFF_FF00, "-100",        12);

    // abort mid-DIV
    @(negedge clk);
    bus.hex = 0; bus.sgn = 0; bus.vi = 32'd12345; bus.en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort busy before", bus.bsy, 1);
    bus.en = 1'b0;
    @(posedge clk); #1;
    chk("abort idle", {bus.bsy, bus.ao, bus.len}, '0);
    wecnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.we) wecnt++;
    end
    chk("abort no writes", wecnt, 0);

    // async reset mid-EMIT
    @(negedge clk);
    bus.hex = 1; bus.sgn = 0; bus.vi = 32'hFFFF_FFFF; bus.en = 1'b1;
    fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(posedge clk); #1;
      if (bus.we) fin = 1;
    end
    chk("reach emit", fin, 1);
    @(posedge clk); #3;
    chk("emit before rst", {bus.we, bus.ao}, {1'b1, 5'd1});
    rst = 1'b1;
    #1;
    chk("async rst", {bus.we, bus.bsy, bus.ao, bus.dout}, '0);
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    directed(0, 0, 32'd7, "7", 37);

    // round trip through the reference parser
    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      bit h, s;
      h = (i >= 100);
      s = 1'($urandom_range(0, 1));
      v = (i % 4 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
      convert(h, s, v);
      chk($sformatf("roundtrip h=%0d s=%0d v=%0h", h, s, v),
          (nwr > 0 && nwr <= 32) ? parse(h, nwr - 1) : ~v, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
